// File: rtl/adder_128_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adder_128_seq_ctrl
// Brief   : Drives one registered 16-bit adder slice through eight passes to
//           form a 128-bit sum, resolving inter-slice carries locally.
// Revision: 1.0 - initial release
// ============================================================================
module adder_128_seq_ctrl #(
  parameter int ADD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_a,
  input  logic [127:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_sum,
  output logic         out_cout,
  output logic [15:0]  add_a,
  output logic [15:0]  add_b,
  output logic         add_en,
  input  logic [15:0]  add_sum,
  input  logic         add_cout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [127:0]       r_a;
  logic [127:0]       r_b;
  logic               r_carry;
  logic [2:0]         r_issue_idx;
  logic [2:0]         r_cap_idx;
  logic [ADD_LAT-1:0] r_sr;
  logic [127:0]       r_sum;
  logic               r_cout;

  logic               w_fire_in;
  logic               w_cap;
  logic               w_cap_last;
  logic [6:0]         w_issue_base;
  logic [6:0]         w_cap_base;
  logic [15:0]        w_slice_sum;
  logic               w_carry_next;

  assign w_fire_in    = in_valid && (r_state == S_IDLE);
  // Only the internal enable history marks valid slice returns; the slice
  // pipeline itself is unreset and may hold stale data.
  assign w_cap        = r_sr[ADD_LAT-1] && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_cap_last   = w_cap && (r_cap_idx == 3'd7);
  assign w_issue_base = {r_issue_idx, 4'b0000};
  assign w_cap_base   = {r_cap_idx, 4'b0000};
  assign w_slice_sum  = add_sum + {15'd0, r_carry};
  assign w_carry_next = add_cout | ((&add_sum) & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_fire_in) w_next_state = S_ISSUE;
      S_ISSUE: if (r_issue_idx == 3'd7) w_next_state = S_DRAIN;
      S_DRAIN: if (w_cap_last) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_en    = 1'b0;
    add_a     = 16'd0;
    add_b     = 16'd0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_ISSUE: begin
        add_en = 1'b1;
        add_a  = r_a[w_issue_base +: 16];
        add_b  = r_b[w_issue_base +: 16];
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_issue_idx <= 3'd0;
      r_cap_idx   <= 3'd0;
      r_sr        <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      r_sr[0] <= add_en;
      for (int k = 1; k < ADD_LAT; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
      if (w_fire_in) begin
        r_a         <= in_a;
        r_b         <= in_b;
        r_carry     <= in_cin;
        r_issue_idx <= 3'd0;
        r_cap_idx   <= 3'd0;
      end else begin
        if (r_state == S_ISSUE) begin
          r_issue_idx <= r_issue_idx + 3'd1;
        end
        if (w_cap) begin
          r_sum[w_cap_base +: 16] <= w_slice_sum;
          r_carry                 <= w_carry_next;
          r_cap_idx               <= r_cap_idx + 3'd1;
          if (r_cap_idx == 3'd7) begin
            r_cout <= w_carry_next;
          end
        end
      end
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_adder_128_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_128_seq_ctrl
// Brief   : Directed and randomized bench with a two-stage 16-bit slice model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_128_seq_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_sum;
  logic         out_cout;
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_en;
  logic [15:0]  add_sum;
  logic         add_cout;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  adder_128_seq_ctrl #(.ADD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unreset slice: input register, then enable-gated output register, Cin=0.
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        s_en;
  always @(posedge clk) begin
    s_a  <= add_a;
    s_b  <= add_b;
    s_en <= add_en;
    if (s_en) {add_cout, add_sum} <= {1'b0, s_a} + {1'b0, s_b};
  end

  task automatic run_add(input logic [127:0] a, input logic [127:0] b, input logic cin,
                         output logic [127:0] sum, output logic cout,
                         output int lat, output int encnt, output logic to);
    int k;
    to = 1'b0; lat = 0; encnt = 0; sum = '0; cout = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin to = 1'b1; return; end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      if (add_en) encnt++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin to = 1'b1; return; end
    sum = out_sum; cout = out_cout;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if ({in_ready, out_valid, add_en, out_cout} !== 4'b1000) $display("FAIL reset_ctrl got=%b want=1000", {in_ready, out_valid, add_en, out_cout});
    else n_pass++;
    n_total++;
    if (out_sum !== 128'd0) $display("FAIL reset_sum got=%h want=0", out_sum);
    else n_pass++;
    n_total++;
    if ({add_a, add_b} !== 32'd0) $display("FAIL reset_add_ab got=%h want=0", {add_a, add_b});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [127:0] s; logic c; int lat; int en; logic to;
    run_add(128'd1, 128'd2, 1'b0, s, c, lat, en, to);
    n_total++;
    if (to) $display("FAIL basic_timeout got=timeout want=result");
    else n_pass++;
    n_total++;
    if ({c, s} !== {1'b0, 128'd3}) $display("FAIL basic_sum got=%b_%h want=0_3", c, s);
    else n_pass++;
    n_total++;
    if (lat !== 10) $display("FAIL basic_latency got=%0d want=10", lat);
    else n_pass++;
    n_total++;
    if (en !== 8) $display("FAIL basic_en_cycles got=%0d want=8", en);
    else n_pass++;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_return_idle got=%b want=10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_full_ripple();
    logic [127:0] s; logic c; int lat; int en; logic to;
    run_add({128{1'b1}}, 128'd0, 1'b1, s, c, lat, en, to);
    n_total++;
    if (to || {c, s} !== {1'b1, 128'd0}) $display("FAIL full_ripple got=%b_%h to=%b want=1_0", c, s, to);
    else n_pass++;
  endtask

  task automatic test_generate();
    logic [127:0] s; logic c; int lat; int en; logic to;
    run_add({128{1'b1}}, {128{1'b1}}, 1'b1, s, c, lat, en, to);
    n_total++;
    if (to || {c, s} !== {1'b1, {128{1'b1}}}) $display("FAIL generate_top got=%b_%h to=%b want=1_ff..ff", c, s, to);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_s; int k; int stable_bad;
    exp_s = {16'h0000, 112'h3};
    in_valid = 1'b1; in_a = {16'h0001, 112'h1}; in_b = {16'hFFFF, 112'h2}; in_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    n_total++;
    if (!out_valid || {out_cout, out_sum} !== {1'b1, exp_s}) $display("FAIL bp_result got=%b_%h valid=%b want=1_%h", out_cout, out_sum, out_valid, exp_s);
    else n_pass++;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 128'hDEAD + 128'(i); in_b = 128'hBEEF; in_cin = 1'b1;
      @(negedge clk);
      if (!out_valid || in_ready || out_sum !== exp_s || out_cout !== 1'b1) stable_bad++;
    end
    n_total++;
    if (stable_bad !== 0) $display("FAIL bp_hold got=%0d_bad_cycles want=0", stable_bad);
    else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    stable_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || !in_ready || add_en) stable_bad++;
      @(negedge clk);
    end
    n_total++;
    if (stable_bad !== 0) $display("FAIL bp_no_latch got=%0d_bad_cycles want=0", stable_bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [127:0] s; logic c; int lat; int en; logic to; int stale;
    in_valid = 1'b1; in_a = {8{16'h8001}}; in_b = {8{16'h9003}}; in_cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (add_en !== 1'b1 || add_a !== 16'h8001) $display("FAIL midop_issue4 got=%b_%h want=1_8001", add_en, add_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready, out_valid, add_en, out_cout, out_sum} !== {4'b1000, 128'd0}) $display("FAIL midop_reset got=%b_%h want=1000_0", {in_ready, out_valid, add_en, out_cout}, out_sum);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL midop_stale got=%0d_bad_cycles want=0", stale);
    else n_pass++;
    run_add(128'd5, 128'd7, 1'b0, s, c, lat, en, to);
    n_total++;
    if (to || {c, s} !== {1'b0, 128'd12} || lat !== 10) $display("FAIL midop_next got=%b_%h lat=%0d want=0_c lat=10", c, s, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k; int t1; int t2;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 128'd10; in_b = 128'd20; in_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_a = 128'd100; in_b = 128'd200; in_cin = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    t1 = cyc;
    n_total++;
    if (!out_valid || {out_cout, out_sum} !== {1'b0, 128'd30}) $display("FAIL b2b_first got=%b_%h valid=%b want=0_1e", out_cout, out_sum, out_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL b2b_idle got=%b want=10", {in_ready, out_valid});
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    t2 = cyc;
    n_total++;
    if (!out_valid || {out_cout, out_sum} !== {1'b0, 128'd301}) $display("FAIL b2b_second got=%b_%h valid=%b want=0_12d", out_cout, out_sum, out_valid);
    else n_pass++;
    n_total++;
    if (t2 - t1 !== 12) $display("FAIL b2b_period got=%0d want=12", t2 - t1);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] a; logic [127:0] b; logic ci; logic [128:0] gold;
    int k; int bad; int done_cnt;
    bad = 0; done_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      a  = {$urandom, $urandom, $urandom, $urandom};
      b  = (n % 7 == 0) ? ~a : {$urandom, $urandom, $urandom, $urandom};
      ci = 1'($urandom_range(0, 1));
      gold = {1'b0, a} + {1'b0, b} + {128'd0, ci};
      k = 0;
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = ci;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (k < 60) begin
        if (out_valid) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_ready) begin
            if ({out_cout, out_sum} !== gold) begin
              bad++;
              if (bad < 4) $display("FAIL rand_sum_%0d got=%b_%h want=%h", n, out_cout, out_sum, gold);
            end
            done_cnt++;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            break;
          end
        end
        @(negedge clk);
        k++;
      end
    end
    n_total++;
    if (bad !== 0) $display("FAIL rand_results got=%0d_wrong want=0", bad);
    else n_pass++;
    n_total++;
    if (done_cnt !== 200) $display("FAIL rand_count got=%0d want=200", done_cnt);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_full_ripple();
    test_generate();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_128_seq_ctrl.md
# adder_128_seq_ctrl

Sequencing controller that lets one registered 16-bit adder slice (`Cin` tied low, `enable`-gated output register) perform full 128-bit additions. It accepts a 128-bit operand pair on a valid/ready handshake and issues eight 16-bit slices, low slice first, one per cycle. It captures each returned `Sum`/`Cout` pair, resolves the inter-slice carry locally, and presents the assembled 128-bit result on a second valid/ready handshake. It sits directly upstream and downstream of the 16-bit adder slice: it drives the slice's `A`/`B`/`enable` and consumes its `Sum`/`Cout`.

## Interface
Parameters:
- `ADD_LAT`, default 2: clock edges from an issue cycle to the cycle in which the slice result is visible on `add_sum`/`add_cout`. 2 matches the registered 16-bit slice.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_a` in 128: operand A.
- `in_b` in 128: operand B.
- `in_cin` in 1: carry-in to bit 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out 128: (A + B + cin) mod 2^128.
- `out_cout` out 1: carry out of bit 127.
- `add_a` out 16: to slice `A`.
- `add_b` out 16: to slice `B`.
- `add_en` out 1: to slice `enable`.
- `add_sum` in 16: from slice `Sum`.
- `add_cout` in 1: from slice `Cout`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_a`, `in_b` and `in_cin`, clear the issue and capture counters, and go to ISSUE.
- ISSUE:
  - Drive `add_a`/`add_b` = operand bits [16i+15:16i] for issue index i = 0..7.
  - Drive `add_en`=1.
  - After i=7, go to DRAIN.
- DRAIN:
  - `add_en`=0.
  - Wait until capture index 7 is taken, then go to DONE.
- DONE:
  - `out_valid`=1, with `out_sum`/`out_cout` held stable.
  - On `out_ready`, go to IDLE.
- Capture tracking:
  - An `ADD_LAT`-deep shift register of `add_en` marks the cycles that carry returning slice results.
  - Tracking uses only this internal shift register. The slice's own unreset pipeline contents are never trusted.
- Carry resolution at capture j (c_prev = latched `in_cin` when j=0):
  - `out_sum[16j+15:16j]` = (`add_sum` + c_prev) mod 2^16.
  - c_j = `add_cout` | (`add_sum`==16'hFFFF & c_prev).
  - `out_cout` = c_7.
- `in_ready`=0 in every state except IDLE. There is no overlap between transactions.
- `add_a`/`add_b` are don't-care while `add_en`=0. Drive them to 0.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `add_en`=0, `add_a`=0, `add_b`=0, counters=0, shift register=0.
- Edge E0 is the input handshake edge.
- Slice i is driven during the cycle after edge E0+i.
- Slice i's result is captured at edge E0+i+1+`ADD_LAT`.
- `out_valid` rises after edge E0+8+`ADD_LAT`. This is edge E0+10 for `ADD_LAT`=2.
- The result handshake at edge Ex returns the block to IDLE, with `in_ready`=1 after Ex. The earliest next input handshake is at edge Ex+1.
- Backpressure: `out_valid` held high and `out_sum`/`out_cout` unchanged for any number of `out_ready`-low cycles.
- `in_valid` while not IDLE is ignored. No operand is latched.
- Reset asserted at any point:
  - All outputs return to reset values immediately.
  - The in-flight transaction is discarded.
  - No `out_valid` pulse is produced for the discarded transaction, including when its slice results return after reset deasserts.
- Throughput: one 128-bit add per 10+`ADD_LAT` cycles when `out_ready` is tied high.

## Test plan
- A=1, B=2, cin=0, `out_ready`=1 → `out_sum`=3, `out_cout`=0, `out_valid` first high after edge E0+10, and `add_en` high for exactly 8 cycles.
- Full ripple: A=2^128−1, B=0, cin=1 → `out_sum`=0, `out_cout`=1. Every slice returns `add_sum`=FFFF with `add_cout`=0, so this exercises the all-ones propagate path.
- Generate at the top: A=2^128−1, B=2^128−1, cin=1 → `out_sum`=2^128−1, `out_cout`=1.
- Backpressure: A=0x0001_0000…, B=0xFFFF_0000…, `out_ready` low for 5 cycles → `out_valid` and result held stable for 5 cycles; the input handshake is refused (`in_ready`=0) while `in_valid`=1 is driven with different operands.
- Reset mid-op: assert `rst_n`=0 during ISSUE slice 4, release it, and run A=5, B=7 → no stale result appears, and the next result is `out_sum`=12.
- Randomized back-to-back: 200 random A, B, cin with random `out_ready` → every result equals a 129-bit golden sum, with results in order and none dropped or duplicated.
